// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the asynchronous FIFO.
// Owns the binary/Gray read pointer, the registered empty, level and almost-empty flags,
// and a three-state output stage. The output stage presents memory data as a
// first-word-fall-through valid/ready stream.
module fifo_rd_ctrl #(
  parameter int unsigned ptr_width  = 8,
  parameter int unsigned data_width = 8,
  parameter int unsigned ae_thresh  = 4
) (
  input  logic                  rdclk,
  input  logic                  rd_rst_n,
  input  logic [ptr_width:0]    wptr_sync,
  output logic [ptr_width:0]    rptr,
  output logic [ptr_width-1:0]  raddr,
  output logic                  mem_ren,
  input  logic [data_width-1:0] rdata_in,
  output logic [data_width-1:0] dout,
  output logic                  dout_valid,
  input  logic                  rd_ready,
  output logic                  fifo_empty,
  output logic                  almost_empty,
  output logic [ptr_width:0]    rd_level
);

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StHold
  } state_e;

  state_e                state_q, state_d;
  logic [ptr_width:0]    rbin_q;
  logic [ptr_width:0]    rbin_next;
  logic [ptr_width:0]    rgray_next;
  logic [ptr_width:0]    wbin_s;
  logic [ptr_width:0]    level_next;
  logic [data_width-1:0] hold_q;
  logic                  load_hold;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [ptr_width:0] gray2bin(input logic [ptr_width:0] g);
    logic [ptr_width:0] b;
    b = g;
    for (int unsigned i = 1; i <= ptr_width; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // Read issue and next pointer values.
  always_comb begin
    dout_valid = (state_q != StIdle);
    // Never read while a word is stalled at the output.
    mem_ren    = !fifo_empty && (!dout_valid || rd_ready);
    rbin_next  = rbin_q + {{ptr_width{1'b0}}, mem_ren};
    rgray_next = rbin_next ^ (rbin_next >> 1);
    wbin_s     = gray2bin(wptr_sync);
    // Full memory gives wbin_s - rbin_next = 2**ptr_width through natural wrap.
    level_next = wbin_s - rbin_next;
    raddr      = rbin_q[ptr_width-1:0];
  end

  // Pointer, empty, level and almost-empty registers.
  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rbin_q       <= '0;
      rptr         <= '0;
      fifo_empty   <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
    end else begin
      rbin_q       <= rbin_next;
      rptr         <= rgray_next;
      fifo_empty   <= (rgray_next == wptr_sync);
      almost_empty <= (32'(level_next) <= ae_thresh);
      rd_level     <= level_next;
    end
  end

  // Output FSM next state, hold-register load and output data mux.
  always_comb begin
    state_d   = state_q;
    load_hold = 1'b0;
    dout      = '0;
    case (state_q)
      StIdle: begin
        if (mem_ren) state_d = StPend;
      end
      StPend: begin
        dout = rdata_in;
        if (rd_ready) begin
          state_d = mem_ren ? StPend : StIdle;
        end else begin
          // Memory data is only valid for one cycle, so capture it.
          state_d   = StHold;
          load_hold = 1'b1;
        end
      end
      StHold: begin
        dout = hold_q;
        if (rd_ready) state_d = mem_ren ? StPend : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output FSM state register.
  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold register captures a stalled word leaving the memory.
  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      hold_q <= '0;
    end else if (load_hold) begin
      hold_q <= rdata_in;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl with a small memory (ptr_width = 3).
// The bench acts as the writer and the memory. Written words go to a scoreboard
// queue, and the words are popped on each dout_valid & rd_ready handshake.
module tb_fifo_rd_ctrl;

  localparam int unsigned PW    = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned AE    = 4;
  localparam int unsigned DEPTH = 1 << PW;

  logic          rdclk = 1'b0;
  logic          clk_en = 1'b0;
  logic          rd_rst_n = 1'b1;
  logic [PW:0]   wptr_sync = '0;
  logic [PW:0]   rptr;
  logic [PW-1:0] raddr;
  logic          mem_ren;
  logic [DW-1:0] rdata_in = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          rd_ready = 1'b0;
  logic          fifo_empty;
  logic          almost_empty;
  logic [PW:0]   rd_level;

  logic [DW-1:0] mem [DEPTH];
  logic [PW:0]   wbin = '0;
  logic [PW:0]   exp_rbin = '0;
  logic [PW:0]   prev_rptr = '0;
  logic          saw_wrap = 1'b0;
  logic [DW-1:0] sb_q [$];
  int            n_checks = 0;
  int            n_fail = 0;

  typedef struct {
    int unsigned nwords;
    logic [PW:0] level;
    logic        ae;
    logic        empty;
  } vec_t;

  vec_t vecs [6];

  fifo_rd_ctrl #(
    .ptr_width  (PW),
    .data_width (DW),
    .ae_thresh  (AE)
  ) dut (
    .rdclk        (rdclk),
    .rd_rst_n     (rd_rst_n),
    .wptr_sync    (wptr_sync),
    .rptr         (rptr),
    .raddr        (raddr),
    .mem_ren      (mem_ren),
    .rdata_in     (rdata_in),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .rd_ready     (rd_ready),
    .fifo_empty   (fifo_empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level)
  );

  always begin
    #5;
    if (clk_en) rdclk = ~rdclk;
  end

  // Memory model: data one cycle after the read enable.
  always @(posedge rdclk) begin
    if (mem_ren) rdata_in <= mem[raddr];
  end

  function automatic logic [PW:0] gray(input logic [PW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rdclk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wbin[PW-1:0]] = d;
    sb_q.push_back(d);
    wbin      = wbin + {{PW{1'b0}}, 1'b1};
    wptr_sync = gray(wbin);
  endtask

  // Resets DUT and writer together; returns at posedge+1 with reset released.
  task automatic do_reset();
    tick();
    rd_rst_n  = 1'b0;
    rd_ready  = 1'b0;
    wbin      = '0;
    wptr_sync = '0;
    @(negedge rdclk);
    tick();
    rd_rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    @(negedge rdclk);
    while (!(fifo_empty && !dout_valid) && i < 50) begin
      @(negedge rdclk);
      i++;
    end
    check("drain_timeout", 32'(i < 50), 32'd1);
    tick();
  endtask

  // Scoreboard and read-pointer model, sampled mid-cycle.
  always @(negedge rdclk) begin
    if (!rd_rst_n) begin
      exp_rbin = '0;
      sb_q.delete();
    end else begin
      check("raddr", 32'(raddr), 32'(exp_rbin[PW-1:0]));
      check("rptr", 32'(rptr), 32'(gray(exp_rbin)));
      if (prev_rptr == 4'b1000 && rptr == 4'b0000) saw_wrap = 1'b1;
      prev_rptr = rptr;
      if (mem_ren) exp_rbin = exp_rbin + {{PW{1'b0}}, 1'b1};
      if (dout_valid && rd_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_extra: got word %0h, required no word", dout);
        end else begin
          check("sb_dout", 32'(dout), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held;
    int i;

    vecs[0] = '{0, 4'd0, 1'b1, 1'b1};
    vecs[1] = '{1, 4'd1, 1'b1, 1'b0};
    vecs[2] = '{4, 4'd4, 1'b1, 1'b0};
    vecs[3] = '{5, 4'd5, 1'b0, 1'b0};
    vecs[4] = '{7, 4'd7, 1'b0, 1'b0};
    vecs[5] = '{8, 4'd8, 1'b0, 1'b0};
    for (int k = 0; k < int'(DEPTH); k++) mem[k] = '0;

    // Reset with the clock stopped.
    #2 rd_rst_n = 1'b0;
    #2;
    check("rst_rptr", 32'(rptr), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_level", 32'(rd_level), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    clk_en = 1'b1;
    @(negedge rdclk);
    tick();
    rd_rst_n = 1'b1;

    // Level / almost-empty / empty one cycle after the write pointer moves.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int unsigned w = 0; w < vecs[v].nwords; w++) push_word(8'(8'h80 + w));
      tick();
      @(negedge rdclk);
      check($sformatf("tbl%0d_level", v), 32'(rd_level), 32'(vecs[v].level));
      check($sformatf("tbl%0d_ae", v), 32'(almost_empty), 32'(vecs[v].ae));
      check($sformatf("tbl%0d_empty", v), 32'(fifo_empty), 32'(vecs[v].empty));
    end

    // Single word.
    do_reset();
    rd_ready = 1'b1;
    push_word(8'hA5);
    @(negedge rdclk);
    check("sw_empty_t", 32'(fifo_empty), 32'd1);
    tick();
    @(negedge rdclk);
    check("sw_empty_t1", 32'(fifo_empty), 32'd0);
    check("sw_ren_t1", 32'(mem_ren), 32'd1);
    check("sw_raddr_t1", 32'(raddr), 32'd0);
    tick();
    @(negedge rdclk);
    check("sw_valid_t2", 32'(dout_valid), 32'd1);
    check("sw_dout_t2", 32'(dout), 32'hA5);
    check("sw_rptr_t2", 32'(rptr), 32'd1);
    check("sw_empty_t2", 32'(fifo_empty), 32'd1);
    tick();
    @(negedge rdclk);
    check("sw_valid_t3", 32'(dout_valid), 32'd0);
    tick();

    // Streaming four words.
    do_reset();
    rd_ready = 1'b1;
    for (int w = 0; w < 4; w++) push_word(8'(8'h10 + w));
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge rdclk);
      check($sformatf("st%0d_ren", k), 32'(mem_ren), 32'd1);
      check($sformatf("st%0d_raddr", k), 32'(raddr), 32'(k));
      check($sformatf("st%0d_level", k), 32'(rd_level), 32'(4 - k));
      check($sformatf("st%0d_ae", k), 32'(almost_empty), 32'd1);
      check($sformatf("st%0d_valid", k), 32'(dout_valid), 32'(k > 0));
    end
    tick();
    @(negedge rdclk);
    check("st_last_valid", 32'(dout_valid), 32'd1);
    check("st_last_rptr", 32'(rptr), 32'd6);
    check("st_last_level", 32'(rd_level), 32'd0);
    check("st_last_ae", 32'(almost_empty), 32'd1);
    check("st_last_ren", 32'(mem_ren), 32'd0);
    tick();
    @(negedge rdclk);
    check("st_end_valid", 32'(dout_valid), 32'd0);
    tick();

    // Backpressure: word stays put, no reads while stalled.
    do_reset();
    push_word(8'h30);
    push_word(8'h31);
    push_word(8'h32);
    held = 8'h30;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge rdclk);
      check($sformatf("bp%0d_valid", k), 32'(dout_valid), 32'd1);
      check($sformatf("bp%0d_dout", k), 32'(dout), 32'(held));
      check($sformatf("bp%0d_ren", k), 32'(mem_ren), 32'd0);
      tick();
    end
    rd_ready = 1'b1;
    @(negedge rdclk);
    check("bp_rel_ren", 32'(mem_ren), 32'd1);
    check("bp_rel_raddr", 32'(raddr), 32'd1);
    check("bp_rel_dout", 32'(dout), 32'(held));
    wait_drain();

    // Wrap: 20 words through an 8-deep memory.
    do_reset();
    rd_ready = 1'b1;
    saw_wrap = 1'b0;
    for (int w = 0; w < 20; w++) begin
      push_word(8'(8'h40 + w));
      tick();
    end
    wait_drain();
    check("wrap_rptr_8_to_0", 32'(saw_wrap), 32'd1);
    check("wrap_final_rptr", 32'(rptr), 32'(gray(4'd4)));
    check("wrap_sb_empty", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset while holding a word.
    do_reset();
    push_word(8'h60);
    push_word(8'h61);
    tick();
    tick();
    tick();
    @(negedge rdclk);
    check("ar_hold_valid", 32'(dout_valid), 32'd1);
    check("ar_hold_ren", 32'(mem_ren), 32'd0);
    #2 rd_rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(dout_valid), 32'd0);
    check("ar_rptr", 32'(rptr), 32'd0);
    check("ar_empty", 32'(fifo_empty), 32'd1);
    check("ar_level", 32'(rd_level), 32'd0);
    @(negedge rdclk);
    tick();
    wbin      = '0;
    wptr_sync = '0;
    rd_rst_n  = 1'b1;
    rd_ready  = 1'b1;
    push_word(8'h70);
    push_word(8'h71);
    i = 0;
    @(negedge rdclk);
    while (!mem_ren && i < 20) begin
      @(negedge rdclk);
      i++;
    end
    check("ar_restart_seen", 32'(i < 20), 32'd1);
    check("ar_restart_raddr", 32'(raddr), 32'd0);
    wait_drain();
    check("end_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
